atom_via_lite: RTL
==================

ATOM_VIA_LITE -- requirements
Module: atom_via_lite

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  CPU clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  register select (0xB8xx decode).
- rnw  in  1  1 = read, 0 = write.
- addr  in  4  register index.
- din  in  8  CPU write data.
- dout  out  8  read data, combinational.
- pa_in  in  8  port A pins.
- pa_out  out  8  port A output value.
- pa_oe  out  8  port A output enables.
- pb_in  in  8  port B pins.
- pb_out  out  8  port B output value.
- pb_oe  out  8  port B output enables.
- irq_n  out  1  interrupt request, active low.

Function
REQ-003 A write SHALL occur on the clk edge where cs=1 and rnw=0. Bus inputs are stable for the whole cycle.
REQ-004 The register map SHALL be:
- 0 ORB/IRB
- 1 ORA
- 2 DDRB
- 3 DDRA
- 4 T1C-L
- 5 T1C-H
- 6 T1L-L
- 7 T1L-H
- 8 T2C-L
- 9 T2C-H
- A SR (reads 0x00, writes ignored)
- B ACR
- C PCR (stored and readable, no function)
- D IFR
- E IER
- F ORA (alias of 1)
REQ-005 dout SHALL be 0x00 when cs=0 or rnw=0.
REQ-006 The port outputs SHALL be:
- pa_out=ORA, pa_oe=DDRA.
- pb_out=ORB, pb_oe=DDRB, except bit 7 as given in REQ-015.
REQ-007 Port reads SHALL be:
- IRB = (ORB&DDRB)|(pb_in&~DDRB), with bit 7 taking the T1 PB7 value when ACR[7]=1.
- IRA = pa_in.
REQ-008 T1 write behaviour SHALL be:
- Writing T1C-L or T1L-L loads t1_lat[7:0].
- Writing T1L-H loads t1_lat[15:8] and clears IFR[6].
- Writing T1C-H loads t1_lat[15:8], loads t1_cnt={din,t1_lat[7:0]}, clears IFR[6], and sets t1_armed=1.
REQ-009 t1_cnt SHALL decrement by 1 every clk cycle. The exception is the cycle after t1_cnt==0, when it takes the ACR[6]=1 value of t1_lat, and otherwise 0xFFFF (16-bit wrap).
REQ-010 On that zero-exit cycle, T1 SHALL set IFR[6] when ACR[6]=1, or when t1_armed=1. In one-shot mode (ACR[6]=0) it SHALL then clear t1_armed.
- Consequence: after writing T1C-H with value N, IFR[6] reads 1 exactly N+1 cycles later.
REQ-011 T2 SHALL behave as follows:
- Writing T2C-L loads t2_lat_lo.
- Writing T2C-H loads t2_cnt={din,t2_lat_lo}, clears IFR[5], and sets t2_armed.
- t2_cnt decrements every cycle and wraps 0x0000→0xFFFF.
- At the wrap, if t2_armed=1, IFR[5] is set and t2_armed cleared.
- ACR[5] pulse-count mode is not implemented; ACR[5] is stored only.
REQ-012 Counter reads SHALL be:
- T1C-L/T1C-H return t1_cnt low/high; reading T1C-L clears IFR[5:6] bit 6 only.
- T1L-L/T1L-H return the latch.
- T2C-L/T2C-H return t2_cnt low/high; reading T2C-L clears IFR[5].
REQ-013 IFR SHALL behave as follows:
- Writing IFR clears each bit [6:0] where din=1.
- IFR[7] = |(IFR[6:0] & IER[6:0]).
- IFR[4:0] have no set sources and remain 0.
REQ-014 IER SHALL behave as follows:
- Writing IER with din[7]=1 sets the IER[6:0] bits where din=1; with din[7]=0 it clears them.
- Reading IER returns {1'b1, IER[6:0]}.
REQ-015 When ACR[7]=1, PB7 SHALL be under T1 control:
- pb_oe[7]=1 and pb_out[7]=t1_pb7.
- Writing T1C-H drives t1_pb7 to 0.
- Each T1 IFR-set event inverts t1_pb7 in free-run mode, or drives it to 1 in one-shot mode.
REQ-016 irq_n SHALL be registered-free, equal to !IFR[7].
REQ-017 Simultaneous events SHALL resolve as follows:
- A T1C-H/T2C-H write in the same cycle as a timeout: the write wins (counter loaded, flag cleared, no set).
- An IFR write-clear or flag-clearing read in the same cycle as a timeout set: the set wins.
- A write to a latch during a free-run reload: the reload uses the pre-write latch value.
REQ-018 A read SHALL have no side effects other than those in REQ-012.

Reset
REQ-019 While reset=1, the block SHALL clear all of ORA, ORB, DDRA, DDRB, ACR, PCR, IFR, IER, t1_lat, t1_cnt, t2_lat_lo, t2_cnt, t1_armed, t2_armed, and t1_pb7.
- Outputs: pa_oe=pb_oe=0x00, pa_out=pb_out=0x00, irq_n=1.
REQ-020 Reset SHALL take precedence over any bus write or timer event in the same cycle. Reset mid-count SHALL produce no interrupt afterwards.

Verification
REQ-021 DDRB=0x0F, ORB=0xA5, pb_in=0x3C → IRB read=0x35, pb_oe=0x0F, pb_out=0xA5.
REQ-022 One-shot: IER←0xC0, T1C-L←0x05, T1C-H←0x00 → IFR[6] rises 6 cycles after the write and irq_n goes low. Reading T1C-L sets irq_n=1, and no further interrupt occurs.
REQ-023 Free-run: ACR←0xC0, latch=0x0003 → IFR[6] is set every 4 cycles after clearing, and pb_out[7] toggles each timeout.
REQ-024 T2: T2C-L←0x02, T2C-H←0x00 → IFR[5] is set 3 cycles later. IER bit 5 clear → irq_n stays 1, IFR read=0x20.
REQ-025 An IFR write of 0x40 in the same cycle as a T1 timeout → IFR[6] stays 1. A T1C-H write on the zero cycle → counter reloaded, IFR[6]=0.
REQ-026 Reset asserted mid-count with IER/IFR set → the next cycle shows irq_n=1, all oe=0, and register reads of 0x00 (IER reads 0x80).

Source files
------------

// File: rtl/atom_via_lite.sv
// Atom 6522-style VIA, reduced: ports A/B, timer 1 (one-shot/free-run, PB7),
// timer 2 (one-shot interval only), IFR/IER interrupt logic. SR reads as zero.
module atom_via_lite (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rnw,
  input  logic [3:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  output logic [7:0] pa_out,
  output logic [7:0] pa_oe,
  input  logic [7:0] pb_in,
  output logic [7:0] pb_out,
  output logic [7:0] pb_oe,
  output logic       irq_n
);

  logic [7:0]  ora, orb, ddra, ddrb, acr, pcr;
  logic [6:0]  ifr, ier;
  logic [15:0] t1_lat, t1_cnt, t2_cnt;
  logic [7:0]  t2_lat_lo;
  logic        t1_armed, t2_armed, t1_pb7;

  logic        wr, rd, irq;
  logic        t1_load, t2_load, t1_zero, t1_fire, t2_fire;
  logic [6:0]  ifr_clr, ifr_set;
  logic [7:0]  irb;

  assign wr = cs & ~rnw;
  assign rd = cs & rnw;

  // A counter-high write in the same cycle as a timeout suppresses the set.
  assign t1_load = wr && (addr == 4'h5);
  assign t2_load = wr && (addr == 4'h9);
  assign t1_zero = (t1_cnt == 16'h0000);
  assign t1_fire = t1_zero && (acr[6] || t1_armed) && !t1_load;
  assign t2_fire = (t2_cnt == 16'h0000) && t2_armed && !t2_load;

  assign ifr_set = {t1_fire, t2_fire, 5'b00000};
  assign irq     = |(ifr & ier);
  assign irq_n   = ~irq;

  assign pa_out = ora;
  assign pa_oe  = ddra;
  assign pb_out = {(acr[7] ? t1_pb7 : orb[7]), orb[6:0]};
  assign pb_oe  = {(acr[7] | ddrb[7]), ddrb[6:0]};

  // Port B input view: output bits read back the latch, input bits the pins.
  always_comb begin
    irb = (orb & ddrb) | (pb_in & ~ddrb);
    if (acr[7]) irb[7] = t1_pb7;
  end

  // Flag clears from bus writes and counter-low reads; sets are applied after.
  always_comb begin
    ifr_clr = '0;
    if (wr && addr == 4'hD) ifr_clr = din[6:0];
    if (wr && (addr == 4'h5 || addr == 4'h7)) ifr_clr[6] = 1'b1;
    if (wr && addr == 4'h9) ifr_clr[5] = 1'b1;
    if (rd && addr == 4'h4) ifr_clr[6] = 1'b1;
    if (rd && addr == 4'h8) ifr_clr[5] = 1'b1;
  end

  // Read mux; zero whenever no read is in progress.
  always_comb begin
    dout = '0;
    if (rd) begin
      case (addr)
        4'h0: dout = irb;
        4'h1: dout = pa_in;
        4'h2: dout = ddrb;
        4'h3: dout = ddra;
        4'h4: dout = t1_cnt[7:0];
        4'h5: dout = t1_cnt[15:8];
        4'h6: dout = t1_lat[7:0];
        4'h7: dout = t1_lat[15:8];
        4'h8: dout = t2_cnt[7:0];
        4'h9: dout = t2_cnt[15:8];
        4'hA: dout = 8'h00;
        4'hB: dout = acr;
        4'hC: dout = pcr;
        4'hD: dout = {irq, ifr};
        4'hE: dout = {1'b1, ier};
        4'hF: dout = pa_in;
      endcase
    end
  end

  // Register file, timers and interrupt flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      ora       <= '0;
      orb       <= '0;
      ddra      <= '0;
      ddrb      <= '0;
      acr       <= '0;
      pcr       <= '0;
      ifr       <= '0;
      ier       <= '0;
      t1_lat    <= '0;
      t1_cnt    <= '0;
      t2_lat_lo <= '0;
      t2_cnt    <= '0;
      t1_armed  <= 1'b0;
      t2_armed  <= 1'b0;
      t1_pb7    <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          4'h0: orb <= din;
          4'h1: ora <= din;
          4'h2: ddrb <= din;
          4'h3: ddra <= din;
          4'h4: t1_lat[7:0] <= din;
          4'h5: t1_lat[15:8] <= din;
          4'h6: t1_lat[7:0] <= din;
          4'h7: t1_lat[15:8] <= din;
          4'h8: t2_lat_lo <= din;
          4'hB: acr <= din;
          4'hC: pcr <= din;
          4'hE: ier <= din[7] ? (ier | din[6:0]) : (ier & ~din[6:0]);
          4'hF: ora <= din;
          default: ;
        endcase
      end

      ifr <= (ifr & ~ifr_clr) | ifr_set;

      // Free-run reload reads t1_lat before any same-cycle latch write lands.
      if (t1_load) begin
        t1_cnt   <= {din, t1_lat[7:0]};
        t1_armed <= 1'b1;
        t1_pb7   <= 1'b0;
      end else if (t1_zero) begin
        t1_cnt <= acr[6] ? t1_lat : 16'hFFFF;
        if (t1_fire) begin
          t1_pb7 <= acr[6] ? ~t1_pb7 : 1'b1;
          if (!acr[6]) t1_armed <= 1'b0;
        end
      end else begin
        t1_cnt <= t1_cnt - 16'd1;
      end

      if (t2_load) begin
        t2_cnt   <= {din, t2_lat_lo};
        t2_armed <= 1'b1;
      end else begin
        t2_cnt <= t2_cnt - 16'd1;
        if (t2_fire) t2_armed <= 1'b0;
      end
    end
  end

endmodule
